mulmod_serial: RTL

- Bit-serial interleaved modular multiplier, Z = X*Y mod M, for the curve448 datapath.
- It is the responder end of the req_valid/req_ready/req_busy/res_valid/res_ready handshake that the point arithmetic sequencers drive when issuing multiply jobs.
- Processes one Y bit per cycle, MSB first, with two conditional subtractions per step.
- Small-area alternative to the full-width multiplier, for area-constrained builds.

---
 rtl/x448_pkg.sv | 15 +
 rtl/mulmod_step.sv | 27 ++
 rtl/mulmod_serial.sv | 121 ++++++++++++
 3 files changed

// File: rtl/x448_pkg.sv
// Shared curve448 constants and the multiplier FSM encoding.
// The modulus P448 = 2^448 - 2^224 - 1 is the default M for the datapath.
package x448_pkg;

  localparam int N448 = 448;

  localparam logic [447:0] P448 = {{223{1'b1}}, 1'b0, {224{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mulmod_step.sv
// One interleaved modular-multiplication step: acc' = (2*acc + bit*x) mod m.
// Requires acc < m and x < m, so at most two subtractions bring the sum below m.
module mulmod_step
  import x448_pkg::*;
#(
  parameter int N = N448
) (
  input  logic [N-1:0] acc,
  input  logic [N-1:0] xr,
  input  logic         y_bit,
  input  logic [N-1:0] m,
  output logic [N-1:0] acc_nxt
);

  logic [N+1:0] m_ext;
  logic [N+1:0] t0;
  logic [N:0]   t1;

  assign m_ext = {2'b00, m};

  // t0 < 3m < 2^(N+2); after one subtraction t1 < 2m < 2^(N+1).
  assign t0 = {1'b0, acc, 1'b0} + (y_bit ? {2'b00, xr} : '0);
  assign t1 = (N+1)'((t0 >= m_ext) ? (t0 - m_ext) : t0);

  assign acc_nxt = N'((t1 >= {1'b0, m}) ? (t1 - {1'b0, m}) : t1);

endmodule

// File: rtl/mulmod_serial.sv
// Bit-serial interleaved modular multiplier Z = X*Y mod M, one Y bit per cycle, MSB first.
// Optional MULMOD_ZERO_BYPASS_EN finishes jobs with a zero operand one edge after acceptance.
module mulmod_serial
  import x448_pkg::*;
#(
  parameter int N     = N448,
  parameter int CNT_W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  input  logic [N-1:0] M,
  output logic [N-1:0] Z,
  input  logic         req_valid,
  output logic         req_ready,
  output logic         req_busy,
  output logic         res_valid,
  input  logic         res_ready,
  output state_t       fsm_state
);

  // Handshake: a job is accepted on the IDLE edge where req_valid is high;
  // req_ready pulses for that one cycle and req_busy stays high until the edge
  // that raises res_valid. res_valid then holds until res_ready is sampled high.
  state_t             state, state_nxt;
  logic [N-1:0]       acc, acc_nxt;
  logic [N-1:0]       xr, xr_nxt;
  logic [N-1:0]       yr, yr_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [N-1:0]       z_nxt;
  logic               ready_nxt, busy_nxt, rv_nxt;
  logic [N-1:0]       step_acc;

  mulmod_step #(.N(N)) u_step (
    .acc     (acc),
    .xr      (xr),
    .y_bit   (yr[cnt]),
    .m       (M),
    .acc_nxt (step_acc)
  );

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    xr_nxt    = xr;
    yr_nxt    = yr;
    cnt_nxt   = cnt;
    z_nxt     = Z;
    ready_nxt = 1'b0;
    busy_nxt  = req_busy;
    rv_nxt    = res_valid;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          ready_nxt = 1'b1;
          busy_nxt  = 1'b1;
          xr_nxt    = X;
          yr_nxt    = Y;
          acc_nxt   = '0;
          cnt_nxt   = CNT_W'(N - 1);
          state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        acc_nxt = step_acc;
        if (cnt == '0) begin
          z_nxt     = step_acc;
          rv_nxt    = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
`ifdef MULMOD_ZERO_BYPASS_EN
        if (xr == '0 || yr == '0) begin
          acc_nxt   = '0;
          z_nxt     = '0;
          rv_nxt    = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = S_DONE;
        end
`endif
      end
      S_DONE: begin
        if (res_ready) begin
          rv_nxt    = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      xr        <= '0;
      yr        <= '0;
      cnt       <= '0;
      Z         <= '0;
      req_ready <= 1'b0;
      req_busy  <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      xr        <= xr_nxt;
      yr        <= yr_nxt;
      cnt       <= cnt_nxt;
      Z         <= z_nxt;
      req_ready <= ready_nxt;
      req_busy  <= busy_nxt;
      res_valid <= rv_nxt;
    end
  end

  assign fsm_state = state;

endmodule
